// File: rtl/seq_det_param.sv
// Serial MSB-first pattern detector with a KMP next-state table built at elaboration.
// Mealy match flag, run-time overlap/non-overlap restart, saturating match counter.
module seq_det_param #(
    parameter int              LEN     = 5,
    parameter logic [LEN-1:0]  PATTERN = 5'b10110,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             ovl,
    input  logic             clr,
    output logic             n,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int K_W = $clog2(LEN);

    generate
        if (LEN < 2 || LEN > 32) begin : g_bad_len
            $error("seq_det_param: LEN must be in 2..32");
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
            $error("seq_det_param: CNT_W must be in 1..32");
        end
    endgenerate

    // Longest proper pattern prefix that is a suffix of (first k pattern bits, then sb).
    // With k = LEN-1 and sb equal to the last pattern bit this yields f(LEN).
    function automatic int kmp_next(input int k, input logic sb);
        int   best;
        int   idx;
        logic ok;
        logic b;
        best = 0;
        for (int l = 1; l < LEN; l++) begin
            if (l <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    idx = k + 1 - l + i;
                    b   = (idx == k) ? sb : PATTERN[LEN-1-idx];
                    if (b != PATTERN[LEN-1-i]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = l;
                end
            end
        end
        return best;
    endfunction

    localparam logic [K_W-1:0] K_LAST = K_W'(LEN - 1);
    localparam logic [K_W-1:0] F_LEN  = K_W'(kmp_next(LEN - 1, PATTERN[0]));

    logic [K_W-1:0] next0_tbl [LEN];
    logic [K_W-1:0] next1_tbl [LEN];
    logic [LEN-1:0] exp_bits;

    genvar gi;
    generate
        for (gi = 0; gi < LEN; gi++) begin : g_tbl
            localparam int T0 = kmp_next(gi, 1'b0);
            localparam int T1 = kmp_next(gi, 1'b1);
            assign next0_tbl[gi] = K_W'(T0);
            assign next1_tbl[gi] = K_W'(T1);
            assign exp_bits[gi]  = PATTERN[LEN-1-gi];
        end
    endgenerate

    logic [K_W-1:0]   k_reg;
    logic [K_W-1:0]   k_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             k_valid;
    logic             hit;

    assign k_valid = (32'(k_reg) < 32'(LEN));

    always_comb begin
        k_next   = k_reg;
        cnt_next = cnt_reg;
        hit      = 1'b0;
        if (clr) begin
            k_next   = '0;
            cnt_next = '0;
        end else if (!k_valid) begin
            k_next = '0;
        end else if (en) begin
            if (s == exp_bits[k_reg] && k_reg == K_LAST) begin
                hit    = 1'b1;
                k_next = ovl ? F_LEN : '0;
                if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                k_next = s ? next1_tbl[k_reg] : next0_tbl[k_reg];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_reg   <= '0;
            cnt_reg <= '0;
        end else begin
            k_reg   <= k_next;
            cnt_reg <= cnt_next;
        end
    end

    // The flag must drop the moment reset asserts, before the state register clears.
    assign n         = hit & rst;
    assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: three instances (default, 2-bit counter, LEN=4 all-ones)
// share one stimulus stream and are checked against a history-window reference model.
module tb_seq_det_param;

    logic clk;
    logic rst;
    logic en;
    logic s;
    logic ovl;
    logic clr;

    logic       n_a;
    logic       n_b;
    logic       n_c;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [7:0] cnt_c;

    int checks;
    int errors;
    int step_no;

    seq_det_param u_a (
        .clk(clk), .rst(rst), .en(en), .s(s), .ovl(ovl), .clr(clr),
        .n(n_a), .match_cnt(cnt_a)
    );

    seq_det_param #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .en(en), .s(s), .ovl(ovl), .clr(clr),
        .n(n_b), .match_cnt(cnt_b)
    );

    seq_det_param #(.LEN(4), .PATTERN(4'b1111)) u_c (
        .clk(clk), .rst(rst), .en(en), .s(s), .ovl(ovl), .clr(clr),
        .n(n_c), .match_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int val;
    } exp_t;

    exp_t q_n[$];
    exp_t q_cnt[$];

    // Reference model: a match is the last LEN accepted bits equalling the pattern,
    // counting only bits accepted since the last restart.
    int          mlen [3] = '{5, 5, 4};
    logic [63:0] mpat [3] = '{64'b10110, 64'b10110, 64'b1111};
    int          mmax [3] = '{255, 3, 255};
    logic [63:0] hist [3];
    int          since[3];
    int          mcnt [3];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int get_n(input int i);
        case (i)
            0:       return int'(n_a);
            1:       return int'(n_b);
            default: return int'(n_c);
        endcase
    endfunction

    function automatic int get_cnt(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i]  = '0;
            since[i] = 0;
            mcnt[i]  = 0;
        end
    endtask

    task automatic model_step(input logic b_en, input logic b_s, input logic b_ovl, input logic b_clr);
        logic [63:0] mask;
        int          exp_n;
        for (int i = 0; i < 3; i++) begin
            exp_n = 0;
            mask  = (64'd1 << mlen[i]) - 64'd1;
            if (b_clr) begin
                since[i] = 0;
                mcnt[i]  = 0;
            end else if (b_en) begin
                hist[i]  = {hist[i][62:0], b_s};
                since[i] = since[i] + 1;
                if (since[i] >= mlen[i] && (hist[i] & mask) == mpat[i]) begin
                    exp_n = 1;
                    if (mcnt[i] < mmax[i]) mcnt[i] = mcnt[i] + 1;
                    if (!b_ovl) since[i] = 0;
                end
            end
            q_n.push_back('{id: i, val: exp_n});
            q_cnt.push_back('{id: i, val: mcnt[i]});
        end
    endtask

    task automatic step(input logic b_en, input logic b_s, input logic b_ovl, input logic b_clr);
        exp_t e;
        @(negedge clk);
        en  = b_en;
        s   = b_s;
        ovl = b_ovl;
        clr = b_clr;
        step_no++;
        model_step(b_en, b_s, b_ovl, b_clr);
        #2;
        for (int i = 0; i < 3; i++) begin
            e = q_n.pop_front();
            check($sformatf("n%0d@%0d", e.id, step_no), get_n(e.id), e.val);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            e = q_cnt.pop_front();
            check($sformatf("cnt%0d@%0d", e.id, step_no), get_cnt(e.id), e.val);
        end
        $display("step %0d en=%b s=%b ovl=%b clr=%b n=%b%b%b cnt=%0d/%0d/%0d",
                 step_no, b_en, b_s, b_ovl, b_clr, n_a, n_b, n_c, cnt_a, cnt_b, cnt_c);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int nb, input logic b_ovl);
        logic [15:0] v;
        v = bits;
        for (int j = nb - 1; j >= 0; j--) begin
            step(1'b1, v[j], b_ovl, 1'b0);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;
        rst = 1'b1;
        en  = 1'b0;
        s   = 1'b0;
        ovl = 1'b0;
        clr = 1'b0;
        model_reset();

        // Power-on reset
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_cnt%0d", i), get_cnt(i), 0);
            check($sformatf("rst_n%0d", i), get_n(i), 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Overlapping: matches on bits 5 and 8
        send_bits(16'b10110110, 8, 1'b1);
        check("ovl_cnt_final", int'(cnt_a), 2);

        // Non-overlapping
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'b10110110, 8, 1'b0);
        check("novl_cnt_a", int'(cnt_a), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'b1011010110, 10, 1'b0);
        check("novl_cnt_b", int'(cnt_a), 2);

        // Stall with s toggling, then completion
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'b101, 3, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(16'b10, 2, 1'b1);
        check("stall_cnt", int'(cnt_a), 1);

        // Same again with clear on the final bit
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'b101, 3, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(16'b1, 1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("clr_cnt", int'(cnt_a), 0);

        // Saturation of the 2-bit counter
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 5; r++) begin
            send_bits(16'b10110, 5, 1'b0);
        end
        check("sat_cnt_b", int'(cnt_b), 3);
        check("sat_cnt_a", int'(cnt_a), 5);

        // Asynchronous reset mid-stream, with a pending match on the input
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'b1011, 4, 1'b1);
        #1;
        en = 1'b1;
        s  = 1'b0;
        #1;
        check("pre_rst_n", int'(n_a), 1);
        rst = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async_cnt%0d", i), get_cnt(i), 0);
            check($sformatf("async_n%0d", i), get_n(i), 0);
        end
        @(posedge clk);
        #1;
        check("rst_hold_cnt", int'(cnt_a), 0);
        check("rst_hold_n", int'(n_a), 0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        send_bits(16'b010110, 6, 1'b1);
        check("post_rst_cnt", int'(cnt_a), 1);

        // All-ones pattern on the LEN=4 instance, both modes
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'b1111111, 7, 1'b1);
        check("ones_ovl_cnt", int'(cnt_c), 4);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'b1111111, 7, 1'b0);
        check("ones_novl_cnt", int'(cnt_c), 1);

        // Random traffic with ovl changing freely and occasional clears
        for (int r = 0; r < 120; r++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d steps expected completion", step_no);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial sequence detector. Compares a 1-bit input stream, MSB-first, against a compile-time pattern of configurable length. It raises a Mealy match flag in the same cycle the final pattern bit arrives. Overlap or non-overlap restart is selectable at run time, and a saturating match counter is provided. It is the general-purpose successor to the fixed-pattern single-mode detectors in the serial-protocol front ends.

## Interface
- `LEN`, 5, pattern length in bits; legal range 2..32; elaboration error outside it.
- `PATTERN`, 5'b10110, `LEN`-bit pattern; `PATTERN[LEN-1]` is the first bit expected.
- `CNT_W`, 8, width of the match counter; legal range 1..32.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: input bit valid; when low, `s` is ignored and state holds.
- `s` in 1: serial data bit.
- `ovl` in 1: 1 = overlapping detection, 0 = non-overlapping.
- `clr` in 1: synchronous clear of state and counter; priority over `en`.
- `n` out 1: Mealy match flag, combinational.
- `match_cnt` out `CNT_W`: registered count of matches, saturating.

## Operation
- **State register `k`:** range 0..LEN-1, width clog2(LEN). `k` is the length of the longest suffix of accepted bits since the last restart that is a proper prefix of `PATTERN`.
- **Failure table `f(j)`** for j = 1..LEN:
  - `f(j)` is the length of the longest proper prefix of `PATTERN` that is also a suffix of its first j bits.
  - The full transition function `T(k,s)` is computed at elaboration (function/generate). It is not computed at run time.
- **Accepted bit** (`en`=1, `clr`=0), in state k with bit s:
  - If `s == PATTERN[LEN-1-k]` and `k == LEN-1`: match.
    - `n` = 1 this cycle.
    - Next `k` = `f(LEN)` if `ovl`=1, else 0.
    - `match_cnt` += 1 unless it is already all-ones.
  - If `s == PATTERN[LEN-1-k]` and `k < LEN-1`: next `k` = k+1.
  - On mismatch: next `k` = `T(k,s)`, the standard KMP fallback (longest prefix that is a suffix of the first k pattern bits followed by s).
  - The fallback applies in both modes. `ovl` only affects the restart after a match.
- **`en`=0:** `k` and `match_cnt` hold; `n` = 0.
- **`clr`=1:**
  - Next `k` = 0 and next `match_cnt` = 0, regardless of `en`/`s`.
  - `n` = 0 that cycle; a coincident would-be match is discarded and not counted.
- **`ovl` sampling:** `ovl` is used only in the match cycle. It may change on any cycle with no other effect.
- **Counter saturation:** at `2^CNT_W - 1` further matches still assert `n` but the count stays.
- **Unused state encodings** (LEN not a power of 2) go to `k` = 0 on the next accepted bit or next clock.

## Timing
- **Reset:** while `rst`=0, `k` = 0 and `match_cnt` = 0 asynchronously, and `n` is forced 0. The first bit accepted is the one on the first rising edge after `rst` deasserts.
- **`n`:** combinational from `k`, `s`, `en`, `clr`, `rst`. It is valid in the same cycle as the last pattern bit; zero latency.
- **`match_cnt`:** reflects a match one cycle after `n` pulses.
- **Back-to-back matches:** with `ovl`=1, matches can be as close as `LEN - f(LEN)` accepted bits. With `ovl`=0 they are at least `LEN` accepted bits apart.
- **Reset mid-stream:** the partial match is lost. Detection restarts from `k` = 0 with no spurious `n`.
- **Input constraint:** inputs must be stable around the rising edge only. No further constraints.

## Test plan
- **Overlap:** defaults, `ovl`=1, `en`=1, stream 1,0,1,1,0,1,1,0.
  - `n` = 1 on bits 5 and 8 only.
  - `match_cnt` = 2 after bit 8.
  - `k` = 2 after each match.
- **Non-overlap:** `ovl`=0, stream 1,0,1,1,0,1,1,0 → `n` = 1 on bit 5 only. Stream 1,0,1,1,0,1,0,1,1,0 → `n` on bits 5 and 10; `match_cnt` = 2.
- **Stall and clear:**
  - Stall: stream 1,0,1 with `en`=1, then 3 cycles `en`=0 with `s` toggling, then 1,0 with `en`=1 → single `n` pulse on the final bit.
  - Clear: repeat with `clr`=1 asserted on the final bit → `n` = 0, and `match_cnt` = 0 next cycle.
- **Saturation:** `CNT_W`=2, 5 non-overlapping matches → `n` pulses 5 times; `match_cnt` sequence 1,2,3,3,3.
- **Reset:** drive `rst`=0 asynchronously between clock edges after bits 1,0,1,1.
  - `match_cnt` and `k` clear immediately.
  - After release, stream 0,1,0,1,1,0 → `n` only on the last bit.
- **Alternate parameters:** `LEN`=4, `PATTERN`=4'b1111, `ovl`=1, seven 1s → `n` on bits 4, 5, 6, 7. With `ovl`=0 → `n` on bit 4 only.
